// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync, shared sample divider, per-channel
// debounce, press pulses and optional auto-repeat on held channels.
module button_conditioner #(
    parameter int                 N_BTN        = 7,
    parameter int                 SAMPLE_DIV   = 50000,
    parameter int                 DB_SAMPLES   = 10,
    parameter logic [N_BTN-1:0]   REPEAT_MASK  = 7'b0000010,
    parameter int                 REPEAT_DELAY = 500,
    parameter int                 REPEAT_RATE  = 100
) (
    input  logic             Clk_in,
    input  logic             Clr,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             tick
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int DB_W  = $clog2(DB_SAMPLES + 1);
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_SAMPLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [DB_W-1:0]  db_cnt_q  [N_BTN];
    logic [DB_W-1:0]  db_cnt_d  [N_BTN];
    logic [REP_W-1:0] rep_cnt_q [N_BTN];
    logic [REP_W-1:0] rep_cnt_d [N_BTN];

    assign tick      = (div_q == DIV_LAST);
    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        level_d   = level_q;
        pulse_d   = '0;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (tick) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        level_d[i]  = sync2_q[i];
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
                // A release on the same tick suppresses any repeat.
                if (REPEAT_MASK[i]) begin
                    if (level_q[i] && level_d[i]) begin
                        if (rep_cnt_q[i] == REP_LAST) begin
                            pulse_d[i]   = 1'b1;
                            rep_cnt_d[i] = REP_LOAD;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                        end
                    end else begin
                        rep_cnt_d[i] = '0;
                    end
                end
            end
            if (!level_q[i] && level_d[i]) begin
                pulse_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_in) begin
        if (!Clr) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            div_q     <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
            db_cnt_q  <= '{default: '0};
            rep_cnt_q <= '{default: '0};
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a
// tick/run-length reference model.
module tb_button_conditioner;

    localparam int         N    = 7;
    localparam int         SD   = 4;
    localparam int         DB   = 3;
    localparam int         RD   = 8;
    localparam int         RR   = 2;
    localparam logic [6:0] MASK = 7'b0000010;

    logic       clk = 1'b0;
    logic       Clr;
    logic [6:0] btn_raw;
    logic [6:0] btn_level;
    logic [6:0] btn_pulse;
    logic       tick;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N), .SAMPLE_DIV(SD), .DB_SAMPLES(DB),
        .REPEAT_MASK(MASK), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .Clk_in(clk), .Clr(Clr), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_pulse(btn_pulse), .tick(tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: raw history, edge count, disagreeing-tick run
    // length and ticks-held since press per channel.
    logic [6:0] h1, h2;
    int         e;
    logic [6:0] m_lvl;
    logic [6:0] m_pulse;
    logic       m_tick;
    int         dis  [N];
    int         held [N];
    int         m_ticks = 0;
    int         pcount [N];

    task automatic model_edge(input logic [6:0] raw, input logic clr);
        bit         t;
        logic [6:0] s;
        logic       nl;
        if (!clr) begin
            h1 = '0; h2 = '0; e = 0;
            m_lvl = '0; m_pulse = '0;
            for (int i = 0; i < N; i++) begin
                dis[i] = 0; held[i] = 0;
            end
        end else begin
            t = ((e + 1) % SD == 0);
            s = h2;
            m_pulse = '0;
            if (t) begin
                m_ticks++;
                for (int i = 0; i < N; i++) begin
                    nl = m_lvl[i];
                    if (s[i] != m_lvl[i]) begin
                        dis[i]++;
                        if (dis[i] == DB) begin
                            nl = s[i]; dis[i] = 0;
                        end
                    end else begin
                        dis[i] = 0;
                    end
                    if (nl && !m_lvl[i]) begin
                        m_pulse[i] = 1'b1; held[i] = 0;
                    end else if (nl && m_lvl[i]) begin
                        held[i]++;
                        if (MASK[i] && held[i] >= RD && (held[i] - RD) % RR == 0)
                            m_pulse[i] = 1'b1;
                    end else begin
                        held[i] = 0;
                    end
                    m_lvl[i] = nl;
                end
            end
            h2 = h1; h1 = raw; e++;
        end
        m_tick = ((e + 1) % SD == 0);
    endtask

    task automatic cyc(input logic [6:0] raw, input logic clr);
        btn_raw = raw;
        Clr     = clr;
        model_edge(raw, clr);
        @(posedge clk);
        #1;
        chk("level", 32'(btn_level), 32'(m_lvl));
        chk("pulse", 32'(btn_pulse), 32'(m_pulse));
        chk("tick",  32'(tick),      32'(m_tick));
        for (int i = 0; i < N; i++)
            if (btn_pulse[i] === 1'b1) pcount[i]++;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N; i++) pcount[i] = 0;
    endtask

    // Raise one channel, wait for the model press, then hold 14 ticks.
    task automatic hold_test(input int ch, input int exp_pulses);
        logic [6:0] r;
        int         p;
        clr_counts();
        r = '0;
        r[ch] = 1'b1;
        for (int k = 0; k < 200 && !m_lvl[ch]; k++) cyc(r, 1'b1);
        chk("press_seen", 32'(m_lvl[ch]), 1);
        p = m_ticks;
        while (m_ticks < p + 14) cyc(r, 1'b1);
        chk("hold_pulses", pcount[ch], exp_pulses);
        for (int k = 0; k < 60; k++) cyc('0, 1'b1);
        chk("hold_released", 32'(btn_level[ch]), 0);
    endtask

    int         p, r, first;
    bit         seen2;
    logic [6:0] rr;

    initial begin
        btn_raw = 7'h7F;
        Clr     = 1'b0;
        clr_counts();

        // Reset with all buttons asserted
        for (int k = 0; k < 3; k++) begin
            cyc(7'h7F, 1'b0);
            chk("rst_level", 32'(btn_level), 0);
            chk("rst_pulse", 32'(btn_pulse), 0);
            chk("rst_tick",  32'(tick), 0);
        end
        // Tick phase after release: seen by edges 4, 8, 12
        for (int k = 1; k <= 12; k++) begin
            cyc('0, 1'b1);
            chk("tick_phase", 32'(tick), (k % 4 == 3) ? 1 : 0);
        end

        // Clean press and release on channel 0
        clr_counts();
        for (int k = 0; k < 200 && !m_lvl[0]; k++) cyc(7'h01, 1'b1);
        chk("clean_press_pulse", pcount[0], 1);
        for (int k = 0; k < 40; k++) cyc(7'h01, 1'b1);
        for (int k = 0; k < 40; k++) cyc('0, 1'b1);
        chk("clean_release_pulse", pcount[0], 1);
        chk("clean_release_level", 32'(btn_level[0]), 0);

        // Bounce on channel 2: 2 ticks high, 1 low, 2 high, low
        clr_counts();
        seen2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(7'h04, 1'b1); seen2 |= btn_level[2];
        end
        for (int k = 0; k < 4; k++) begin
            cyc('0, 1'b1); seen2 |= btn_level[2];
        end
        for (int k = 0; k < 8; k++) begin
            cyc(7'h04, 1'b1); seen2 |= btn_level[2];
        end
        for (int k = 0; k < 40; k++) begin
            cyc('0, 1'b1); seen2 |= btn_level[2];
        end
        chk("bounce_level", 32'(seen2), 0);
        chk("bounce_pulse", pcount[2], 0);

        // Auto-repeat on Up, none on unmasked channel 3
        hold_test(1, 5);
        hold_test(3, 1);

        // Simultaneous press on channels 4 and 5
        clr_counts();
        for (int k = 0; k < 200 && !m_lvl[4]; k++) cyc(7'h30, 1'b1);
        chk("simul_same_cycle", 32'(btn_pulse[5:4]), 3);
        for (int k = 0; k < 60; k++) cyc(7'h30, 1'b1);
        for (int k = 0; k < 40; k++) cyc('0, 1'b1);
        chk("simul_pulse4", pcount[4], 1);
        chk("simul_pulse5", pcount[5], 1);

        // Reset while Up is held and repeating
        for (int k = 0; k < 200 && !m_lvl[1]; k++) cyc(7'h02, 1'b1);
        p = m_ticks;
        while (m_ticks < p + 9) cyc(7'h02, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cyc(7'h02, 1'b0);
            chk("midrst_level", 32'(btn_level), 0);
            chk("midrst_pulse", 32'(btn_pulse), 0);
        end
        clr_counts();
        r = m_ticks;
        first = -1;
        while (m_ticks < r + 10) begin
            cyc(7'h02, 1'b1);
            if (btn_pulse[1] === 1'b1 && first < 0) first = m_ticks - r;
        end
        chk("midrst_press_tick", first, 3);
        chk("midrst_no_early_rep", pcount[1], 1);
        while (m_ticks < r + 11) cyc(7'h02, 1'b1);
        chk("midrst_first_rep", pcount[1], 2);
        for (int k = 0; k < 40; k++) cyc('0, 1'b1);

        // Random toggling with occasional reset
        rr = '0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, (i == 1) ? 119 : 39) == 0) rr[i] = ~rr[i];
            cyc(rr, ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
